// File: rtl/agc_pkg.sv
// Shared widths, state encoding and helpers for the I/Q automatic gain control.
package agc_pkg;

   localparam int SAMPLE_W = 12;
   localparam int MANT_W   = 8;
   localparam int EXP_W    = 4;
   localparam int LVL_W    = 8;

   typedef enum logic {
      LOAD,
      RUN
   } state_t;

   // |v| for a 12-bit two's complement sample; |-2048| = 2048 needs 13 bits
   function automatic logic [SAMPLE_W:0] abs13(logic [SAMPLE_W-1:0] v);
      logic signed [SAMPLE_W:0] s;
      s = {v[SAMPLE_W-1], v};
      return s[SAMPLE_W] ? (SAMPLE_W+1)'(-s) : (SAMPLE_W+1)'(s);
   endfunction

endpackage

// File: rtl/agc_scaler.sv
// One rail of the gain stage: capture, mantissa multiply, exponent shift, saturate.
module agc_scaler
   import agc_pkg::*;
#(
   parameter int EXP_BIAS = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cap,
   input  logic                mul,
   input  logic                fin,
   input  logic [SAMPLE_W-1:0] x,
   input  logic [MANT_W-1:0]   m,
   input  logic [EXP_W-1:0]    e,
   output logic [SAMPLE_W-1:0] y
);

   localparam int P_W = 21;
   localparam int W_W = 36;

   logic signed [SAMPLE_W-1:0] x_r;
   logic signed [P_W-1:0]      p_r;
   logic [EXP_W-1:0]           e_r;
   logic signed [9:0]          gain;
   logic signed [21:0]         prod;
   logic signed [W_W-1:0]      wide;
   logic signed [W_W-1:0]      shr;
   logic [SAMPLE_W-1:0]        sat;

   always_comb begin
      gain = $signed({2'b01, m});
      prod = x_r * gain;
      wide = $signed({{(W_W-P_W){p_r[P_W-1]}}, p_r}) <<< e_r;
      shr  = wide >>> (8 + EXP_BIAS);
      sat  = shr[SAMPLE_W-1:0];
      if (shr > 36'sd2047)
         sat = 12'h7FF;
      else if (shr < -36'sd2048)
         sat = 12'h800;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_r <= '0;
         p_r <= '0;
         e_r <= '0;
         y   <= '0;
      end else begin
         if (cap)
            x_r <= $signed(x);
         // exponent travels with the product so both use the T+2 gain
         if (mul) begin
            p_r <= prod[P_W-1:0];
            e_r <= e;
         end
         if (fin)
            y <= sat;
      end
   end

endmodule

// File: rtl/agc.sv
// Automatic gain control: strobe detect, two scaler rails, level averaging and gain loop.
module agc
   import agc_pkg::*;
#(
   parameter int EXP_BIAS = 10,
   parameter int STEP     = 8,
   parameter int HYST     = 8,
   parameter int AVG_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk_8,
   input  logic [SAMPLE_W-1:0] sample_i,
   input  logic [SAMPLE_W-1:0] sample_q,
   input  logic [LVL_W-1:0]    threshold,
   input  logic [MANT_W-1:0]   mantissa,
   input  logic [EXP_W-1:0]    exp,
   output logic [SAMPLE_W-1:0] out_i,
   output logic [SAMPLE_W-1:0] out_q,
   output logic                out_valid,
   output logic [MANT_W-1:0]   gain_mantissa,
   output logic [EXP_W-1:0]    gain_exp
);

   localparam int SUM_W = LVL_W + AVG_LOG2;
   localparam logic [MANT_W-1:0] STEP_M  = MANT_W'(STEP);
   localparam logic [MANT_W-1:0] INC_LIM = MANT_W'(255 - STEP);
   localparam logic signed [9:0] HYST_S  = 10'(HYST);

   state_t               state;
   logic                 clk_8_d;
   logic                 v1;
   logic                 v2;
   logic [MANT_W-1:0]    m;
   logic [EXP_W-1:0]     e;
   logic [SUM_W-1:0]     sum;
   logic [AVG_LOG2-1:0]  cnt;

   logic                 strobe;
   logic [SAMPLE_W:0]    a;
   logic [SAMPLE_W:0]    b;
   logic [SAMPLE_W:0]    mag;
   logic [10:0]          clamp;
   logic [LVL_W-1:0]     lvl;
   logic [SUM_W-1:0]     sum_nxt;
   logic signed [9:0]    avg;
   logic signed [9:0]    hi;
   logic signed [9:0]    lo;
   logic                 inc;
   logic                 dec;
   logic                 win_end;

   assign strobe        = clk_8 & ~clk_8_d & (state == RUN);
   assign gain_mantissa = m;
   assign gain_exp      = e;

   agc_scaler #(.EXP_BIAS(EXP_BIAS)) u_i (
      .clk(clk), .rst(rst), .cap(strobe), .mul(v1), .fin(v2),
      .x(sample_i), .m(m), .e(e), .y(out_i)
   );

   agc_scaler #(.EXP_BIAS(EXP_BIAS)) u_q (
      .clk(clk), .rst(rst), .cap(strobe), .mul(v1), .fin(v2),
      .x(sample_q), .m(m), .e(e), .y(out_q)
   );

   // max + min/2 magnitude estimate, clamped and reduced to Q0.8
   always_comb begin
      a       = abs13(out_i);
      b       = abs13(out_q);
      mag     = (a > b) ? a + (b >> 1) : b + (a >> 1);
      clamp   = (mag > 13'd2047) ? 11'h7FF : mag[10:0];
      lvl     = clamp[10:3];
      sum_nxt = sum + SUM_W'(lvl);
      avg     = $signed({2'b00, sum_nxt[SUM_W-1:AVG_LOG2]});
      hi      = $signed({2'b00, threshold}) + HYST_S;
      lo      = $signed({2'b00, threshold}) - HYST_S;
      dec     = avg > hi;
      inc     = avg < lo;
      win_end = out_valid && (cnt == '1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= LOAD;
         clk_8_d   <= 1'b1;
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         m         <= '0;
         e         <= '0;
         sum       <= '0;
         cnt       <= '0;
      end else begin
         clk_8_d   <= clk_8;
         v1        <= strobe;
         v2        <= v1;
         out_valid <= v2;
         unique case (state)
            LOAD: begin
               m     <= mantissa;
               e     <= exp;
               state <= RUN;
            end
            RUN: begin
               if (out_valid) begin
                  cnt <= cnt + 1'b1;
                  sum <= win_end ? '0 : sum_nxt;
               end
               if (win_end && inc) begin
                  if (m <= INC_LIM)
                     m <= m + STEP_M;
                  else if (e != 4'd15) begin
                     e <= e + 1'b1;
                     m <= '0;
                  end else
                     m <= 8'd255;
               end else if (win_end && dec) begin
                  if (m >= STEP_M)
                     m <= m - STEP_M;
                  else if (e != 4'd0) begin
                     e <= e - 1'b1;
                     m <= 8'd255;
                  end else
                     m <= '0;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_agc.sv
// Directed bench for agc: table of single-sample gain vectors plus loop/reset sequences.
module tb_agc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clk_8 = 1'b0;
   logic [11:0] sample_i = '0;
   logic [11:0] sample_q = '0;
   logic [7:0]  threshold = 8'h80;
   logic [7:0]  mantissa = '0;
   logic [3:0]  exp = 4'd10;
   logic [11:0] out_i;
   logic [11:0] out_q;
   logic        out_valid;
   logic [7:0]  gain_mantissa;
   logic [3:0]  gain_exp;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   agc dut (
      .clk(clk), .rst(rst), .clk_8(clk_8),
      .sample_i(sample_i), .sample_q(sample_q),
      .threshold(threshold), .mantissa(mantissa), .exp(exp),
      .out_i(out_i), .out_q(out_q), .out_valid(out_valid),
      .gain_mantissa(gain_mantissa), .gain_exp(gain_exp)
   );

   typedef struct {
      logic [7:0]  m;
      logic [3:0]  e;
      logic [11:0] i;
      logic [11:0] q;
      logic [11:0] ei;
      logic [11:0] eq;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic do_reset(input logic [7:0] m, input logic [3:0] e, input logic [7:0] t);
      @(negedge clk);
      rst = 1'b0;
      clk_8 = 1'b0;
      mantissa = m;
      exp = e;
      threshold = t;
      @(negedge clk);
      check("rst_out_i", 32'(out_i), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_gain_m", 32'(gain_mantissa), 0);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   // one clk_8 period (4 high, 4 low); inputs are scrambled after capture
   task automatic run_sample(input logic [11:0] i, input logic [11:0] q,
                             output logic [11:0] ri, output logic [11:0] rq,
                             output int lat, output int nv);
      ri = '0; rq = '0; lat = -1; nv = 0;
      @(negedge clk);
      sample_i = i;
      sample_q = q;
      clk_8 = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (k == 0) begin
            sample_i = ~i;
            sample_q = ~q;
         end
         if (k == 3)
            clk_8 = 1'b0;
         if (out_valid) begin
            nv++;
            if (lat < 0) begin
               lat = k;
               ri = out_i;
               rq = out_q;
            end
         end
      end
   endtask

   task automatic run_many(input int n, input logic [11:0] i, input logic [11:0] q);
      logic [11:0] ri, rq;
      int lat, nv;
      for (int s = 0; s < n; s++)
         run_sample(i, q, ri, rq, lat, nv);
   endtask

   initial begin
      logic [11:0] ri, rq;
      int lat, nv, seen;

      tbl[0] = '{8'd0,   4'd10, 12'h400, 12'h000, 12'h400, 12'h000};
      tbl[1] = '{8'd128, 4'd11, 12'h100, 12'hF00, 12'h300, 12'hD00};
      tbl[2] = '{8'd0,   4'd12, 12'h7FF, 12'h800, 12'h7FF, 12'h800};
      tbl[3] = '{8'd0,   4'd12, 12'h100, 12'hF00, 12'h400, 12'hC00};
      tbl[4] = '{8'd0,   4'd10, 12'h001, 12'hFFF, 12'h001, 12'hFFF};
      tbl[5] = '{8'd0,   4'd9,  12'h001, 12'hFFF, 12'h000, 12'hFFF};
      tbl[6] = '{8'd255, 4'd15, 12'h010, 12'h000, 12'h3FE, 12'h000};
      tbl[7] = '{8'd0,   4'd0,  12'h7FF, 12'h800, 12'h001, 12'hFFE};

      for (int v = 0; v < 8; v++) begin
         do_reset(tbl[v].m, tbl[v].e, 8'h80);
         check("load_m", 32'(gain_mantissa), 32'(tbl[v].m));
         check("load_e", 32'(gain_exp), 32'(tbl[v].e));
         run_sample(tbl[v].i, tbl[v].q, ri, rq, lat, nv);
         check("vec_out_i", 32'(ri), 32'(tbl[v].ei));
         check("vec_out_q", 32'(rq), 32'(tbl[v].eq));
         check("vec_latency", 32'(lat), 2);
         check("vec_pulses", 32'(nv), 1);
      end

      // level exactly on threshold: gain holds
      do_reset(8'd0, 4'd10, 8'h80);
      run_many(16, 12'h400, 12'h000);
      check("hold_m", 32'(gain_mantissa), 0);
      check("hold_e", 32'(gain_exp), 10);

      // full-scale input: exponent borrow, then mantissa steps down
      do_reset(8'd0, 4'd10, 8'h80);
      run_many(15, 12'h7FF, 12'h000);
      check("dec_pre_m", 32'(gain_mantissa), 0);
      run_many(1, 12'h7FF, 12'h000);
      check("dec1_m", 32'(gain_mantissa), 255);
      check("dec1_e", 32'(gain_exp), 9);
      run_sample(12'h7FF, 12'h000, ri, rq, lat, nv);
      check("dec_gain_out", 32'(ri), 32'h7FB);
      run_many(15, 12'h7FF, 12'h000);
      check("dec2_m", 32'(gain_mantissa), 247);
      run_many(16, 12'h7FF, 12'h000);
      check("dec3_m", 32'(gain_mantissa), 239);
      check("dec3_e", 32'(gain_exp), 9);

      // small input, high threshold: gain climbs to saturation
      do_reset(8'd240, 4'd14, 8'hFF);
      run_many(16, 12'h010, 12'h010);
      check("inc1_m", 32'(gain_mantissa), 248);
      run_many(16, 12'h010, 12'h010);
      check("inc2_m", 32'(gain_mantissa), 0);
      check("inc2_e", 32'(gain_exp), 15);
      run_many(16, 12'h010, 12'h010);
      check("inc3_m", 32'(gain_mantissa), 8);
      run_many(16 * 34, 12'h010, 12'h010);
      check("inc_sat_m", 32'(gain_mantissa), 255);
      check("inc_sat_e", 32'(gain_exp), 15);

      // reset while a sample is in flight
      do_reset(8'd128, 4'd11, 8'h80);
      run_sample(12'h100, 12'h000, ri, rq, lat, nv);
      check("pre_mid_out", 32'(ri), 32'h300);
      @(negedge clk);
      sample_i = 12'h100;
      clk_8 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_out_i", 32'(out_i), 0);
      check("mid_valid", 32'(out_valid), 0);
      check("mid_gain_m", 32'(gain_mantissa), 0);
      check("mid_gain_e", 32'(gain_exp), 0);
      mantissa = 8'd0;
      exp = 4'd10;
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      clk_8 = 1'b0;
      rst = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mid_no_valid", 32'(seen), 0);
      check("reload_m", 32'(gain_mantissa), 0);
      check("reload_e", 32'(gain_exp), 10);
      run_sample(12'h400, 12'h000, ri, rq, lat, nv);
      check("post_mid_out", 32'(ri), 32'h400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
